// File: rtl/morse_encoder.sv
// morse_encoder: keys one ASCII character per handshake out as International
// Morse on key_out, with all timing counted in clk_100Mhz ticks.
// Optional build macro: SIDETONE_EN adds a square-wave sidetone on tone_out
// while the key is down; without it tone_out is tied low.
module morse_encoder #(
    parameter int unsigned UNIT_TICKS       = 50_000_000,
    parameter int unsigned TONE_HALF_PERIOD = 50_000
) (
    input  logic       clk_100Mhz,
    input  logic       reset_n,
    input  logic [7:0] char_data,
    input  logic       char_valid,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       err_pulse,
    output logic       tone_out
);

    localparam int unsigned CW = $clog2(4 * UNIT_TICKS + 1);

    localparam logic [CW-1:0] DOT_LOAD  = CW'(UNIT_TICKS - 1);
    localparam logic [CW-1:0] DASH_LOAD = CW'(3 * UNIT_TICKS - 1);
    localparam logic [CW-1:0] CHAR_LOAD = CW'(3 * UNIT_TICKS - 1);
    localparam logic [CW-1:0] WORD_LOAD = CW'(4 * UNIT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MARK     = 3'd1,
        ELEM_GAP = 3'd2,
        CHAR_GAP = 3'd3,
        WORD_GAP = 3'd4
    } state_t;

    // Code table entry: pat is left-aligned, pat[4] is sent first, 1 = dash.
    typedef struct packed {
        logic       ok;
        logic       space;
        logic [2:0] len;
        logic [4:0] pat;
    } code_t;

    function automatic code_t mk(input logic [2:0] l, input logic [4:0] p);
        code_t r;
        r.ok    = 1'b1;
        r.space = 1'b0;
        r.len   = l;
        r.pat   = p;
        return r;
    endfunction

    // Case-folded ASCII to Morse lookup; unsupported characters return ok = 0.
    function automatic code_t lookup(input logic [7:0] c);
        logic [7:0] u;
        code_t      r;
        r = '0;
        u = (c >= 8'h61 && c <= 8'h7a) ? c - 8'h20 : c;
        case (u)
            8'h20: begin r.ok = 1'b1; r.space = 1'b1; end
            8'h41: r = mk(3'd2, 5'b01000);   // A .-
            8'h42: r = mk(3'd4, 5'b10000);   // B -...
            8'h43: r = mk(3'd4, 5'b10100);   // C -.-.
            8'h44: r = mk(3'd3, 5'b10000);   // D -..
            8'h45: r = mk(3'd1, 5'b00000);   // E .
            8'h46: r = mk(3'd4, 5'b00100);   // F ..-.
            8'h47: r = mk(3'd3, 5'b11000);   // G --.
            8'h48: r = mk(3'd4, 5'b00000);   // H ....
            8'h49: r = mk(3'd2, 5'b00000);   // I ..
            8'h4a: r = mk(3'd4, 5'b01110);   // J .---
            8'h4b: r = mk(3'd3, 5'b10100);   // K -.-
            8'h4c: r = mk(3'd4, 5'b01000);   // L .-..
            8'h4d: r = mk(3'd2, 5'b11000);   // M --
            8'h4e: r = mk(3'd2, 5'b10000);   // N -.
            8'h4f: r = mk(3'd3, 5'b11100);   // O ---
            8'h50: r = mk(3'd4, 5'b01100);   // P .--.
            8'h51: r = mk(3'd4, 5'b11010);   // Q --.-
            8'h52: r = mk(3'd3, 5'b01000);   // R .-.
            8'h53: r = mk(3'd3, 5'b00000);   // S ...
            8'h54: r = mk(3'd1, 5'b10000);   // T -
            8'h55: r = mk(3'd3, 5'b00100);   // U ..-
            8'h56: r = mk(3'd4, 5'b00010);   // V ...-
            8'h57: r = mk(3'd3, 5'b01100);   // W .--
            8'h58: r = mk(3'd4, 5'b10010);   // X -..-
            8'h59: r = mk(3'd4, 5'b10110);   // Y -.--
            8'h5a: r = mk(3'd4, 5'b11000);   // Z --..
            8'h30: r = mk(3'd5, 5'b11111);   // 0 -----
            8'h31: r = mk(3'd5, 5'b01111);   // 1 .----
            8'h32: r = mk(3'd5, 5'b00111);   // 2 ..---
            8'h33: r = mk(3'd5, 5'b00011);   // 3 ...--
            8'h34: r = mk(3'd5, 5'b00001);   // 4 ....-
            8'h35: r = mk(3'd5, 5'b00000);   // 5 .....
            8'h36: r = mk(3'd5, 5'b10000);   // 6 -....
            8'h37: r = mk(3'd5, 5'b11000);   // 7 --...
            8'h38: r = mk(3'd5, 5'b11100);   // 8 ---..
            8'h39: r = mk(3'd5, 5'b11110);   // 9 ----.
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    shreg_q, shreg_d;
    logic [2:0]    elem_q, elem_d;
    logic          key_q, ready_q, busy_q, err_q;

    code_t code_c;
    logic  accept_c;

    assign code_c   = lookup(char_data);
    assign accept_c = char_valid && (state_q == IDLE);

    // Next-state, counter load and element sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        shreg_d = shreg_q;
        elem_d  = elem_q;
        case (state_q)
            IDLE: begin
                if (accept_c && code_c.ok) begin
                    if (code_c.space) begin
                        state_d = WORD_GAP;
                        cnt_d   = WORD_LOAD;
                    end else begin
                        state_d = MARK;
                        cnt_d   = code_c.pat[4] ? DASH_LOAD : DOT_LOAD;
                        shreg_d = {code_c.pat[3:0], 1'b0};
                        elem_d  = code_c.len - 3'd1;
                    end
                end
            end
            MARK: begin
                if (cnt_q == '0) begin
                    if (elem_q == '0) begin
                        state_d = CHAR_GAP;
                        cnt_d   = CHAR_LOAD;
                    end else begin
                        state_d = ELEM_GAP;
                        cnt_d   = DOT_LOAD;
                    end
                end
            end
            ELEM_GAP: begin
                if (cnt_q == '0) begin
                    state_d = MARK;
                    cnt_d   = shreg_q[4] ? DASH_LOAD : DOT_LOAD;
                    shreg_d = {shreg_q[3:0], 1'b0};
                    elem_d  = elem_q - 3'd1;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk_100Mhz) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            elem_q  <= '0;
            key_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            elem_q  <= elem_d;
            key_q   <= (state_d == MARK);
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
            err_q   <= accept_c && !code_c.ok;
        end
    end

    assign char_ready = ready_q;
    assign key_out    = key_q;
    assign busy       = busy_q;
    assign err_pulse  = err_q;

`ifdef SIDETONE_EN
    localparam int unsigned TW = $clog2(TONE_HALF_PERIOD + 1);

    logic          tone_q;
    logic [TW-1:0] tcnt_q;

    // Sidetone: starts high on the first mark cycle, toggles every half-period.
    always_ff @(posedge clk_100Mhz) begin
        if (!reset_n || (state_d != MARK)) begin
            tone_q <= 1'b0;
            tcnt_q <= '0;
        end else if (!key_q) begin
            tone_q <= 1'b1;
            tcnt_q <= TW'(TONE_HALF_PERIOD - 1);
        end else if (tcnt_q == '0) begin
            tone_q <= ~tone_q;
            tcnt_q <= TW'(TONE_HALF_PERIOD - 1);
        end else begin
            tcnt_q <= tcnt_q - TW'(1);
        end
    end

    assign tone_out = tone_q;
`else
    assign tone_out = 1'b0;
`endif

endmodule

// File: tb/tb_morse_encoder.sv
// tb_morse_encoder: randomized character stream checked cycle-by-cycle
// against a Morse-string reference model (UNIT_TICKS = 4, TONE_HALF_PERIOD = 2).
module tb_morse_encoder;

    localparam int unsigned U = 4;
    localparam int unsigned T = 2;
`ifdef SIDETONE_EN
    localparam bit TONE_ON = 1'b1;
`else
    localparam bit TONE_ON = 1'b0;
`endif

    logic       clk_100Mhz = 1'b0;
    logic       reset_n;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       err_pulse;
    logic       tone_out;

    int n_checks = 0;
    int n_errors = 0;
    bit wave[$];

    always #5 clk_100Mhz = ~clk_100Mhz;

    morse_encoder #(.UNIT_TICKS(U), .TONE_HALF_PERIOD(T)) dut (
        .clk_100Mhz (clk_100Mhz),
        .reset_n    (reset_n),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .key_out    (key_out),
        .busy       (busy),
        .err_pulse  (err_pulse),
        .tone_out   (tone_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_100Mhz);
        @(negedge clk_100Mhz);
    endtask

    // Dot/dash text for a character; ok = 0 when it has no Morse code.
    function automatic string morse_of(input logic [7:0] c, output bit ok);
        logic [7:0] u;
        u  = (c >= "a" && c <= "z") ? c - 8'd32 : c;
        ok = 1'b1;
        case (u)
            " ": return "";
            "A": return ".-";    "B": return "-...";  "C": return "-.-.";
            "D": return "-..";   "E": return ".";     "F": return "..-.";
            "G": return "--.";   "H": return "....";  "I": return "..";
            "J": return ".---";  "K": return "-.-";   "L": return ".-..";
            "M": return "--";    "N": return "-.";    "O": return "---";
            "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
            "S": return "...";   "T": return "-";     "U": return "..-";
            "V": return "...-";  "W": return ".--";   "X": return "-..-";
            "Y": return "-.--";  "Z": return "--..";
            "0": return "-----"; "1": return ".----"; "2": return "..---";
            "3": return "...--"; "4": return "....-"; "5": return ".....";
            "6": return "-...."; "7": return "--..."; "8": return "---..";
            "9": return "----.";
            default: begin
                ok = 1'b0;
                return "";
            end
        endcase
    endfunction

    // Expected key_out waveform for the busy period of one character.
    function automatic void build_wave(input logic [7:0] c, output bit ok);
        string s;
        s = morse_of(c, ok);
        wave.delete();
        if (!ok) return;
        if (s.len() == 0) begin
            for (int i = 0; i < 4 * U; i++) wave.push_back(1'b0);
            return;
        end
        for (int j = 0; j < s.len(); j++) begin
            int mark_len;
            mark_len = (s[j] == 8'h2d) ? 3 * U : U;
            for (int i = 0; i < mark_len; i++) wave.push_back(1'b1);
            if (j != s.len() - 1)
                for (int i = 0; i < U; i++) wave.push_back(1'b0);
        end
        for (int i = 0; i < 3 * U; i++) wave.push_back(1'b0);
    endfunction

    // Transfer one character, then check every busy cycle and the return to ready.
    task automatic send_char(input logic [7:0] c);
        bit ok;
        int pos;
        bit exp_tone;
        build_wave(c, ok);
        char_data  = c;
        char_valid = 1'b1;
        tick();
        if (!ok) begin
            check("err_pulse_bad", 32'(err_pulse), 1);
            check("ready_bad", 32'(char_ready), 1);
            check("busy_bad", 32'(busy), 0);
            check("key_bad", 32'(key_out), 0);
            char_valid = 1'b0;
            return;
        end
        pos = 0;
        for (int i = 0; i < wave.size(); i++) begin
            if (wave[i]) pos = (i > 0 && wave[i-1]) ? pos + 1 : 0;
            exp_tone = TONE_ON && wave[i] && (((pos / T) % 2) == 0);
            check("key", 32'(key_out), 32'(wave[i]));
            check("busy", 32'(busy), 1);
            check("ready_busy", 32'(char_ready), 0);
            check("err_quiet", 32'(err_pulse), 0);
            check("tone", 32'(tone_out), 32'(exp_tone));
            char_valid = 1'($urandom_range(0, 1));
            char_data  = 8'($urandom);
            tick();
        end
        check("ready_done", 32'(char_ready), 1);
        check("busy_done", 32'(busy), 0);
        check("key_done", 32'(key_out), 0);
        char_valid = 1'b0;
    endtask

    function automatic logic [7:0] rand_char();
        case ($urandom_range(0, 5))
            0: return 8'("A" + $urandom_range(0, 25));
            1: return 8'("a" + $urandom_range(0, 25));
            2: return 8'("0" + $urandom_range(0, 9));
            3: return " ";
            4: return 8'($urandom);
            default: return 8'("!" + $urandom_range(0, 14));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        tick();
        tick();
        check("rst_ready", 32'(char_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_key", 32'(key_out), 0);
        check("rst_err", 32'(err_pulse), 0);
        check("rst_tone", 32'(tone_out), 0);
        reset_n = 1'b1;
        tick();
        check("idle_ready", 32'(char_ready), 1);

        send_char("E");
        send_char("a");
        send_char("0");
        send_char(" ");
        send_char("T");
        send_char("#");
        send_char("E");

        for (int n = 0; n < 40; n++) send_char(rand_char());

        // Reset in the middle of a dash.
        char_data  = "T";
        char_valid = 1'b1;
        tick();
        char_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("pre_rst_key", 32'(key_out), 1);
            tick();
        end
        check("pre_rst_key", 32'(key_out), 1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_key", 32'(key_out), 0);
        check("mid_rst_ready", 32'(char_ready), 1);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_tone", 32'(tone_out), 0);
        reset_n = 1'b1;
        send_char("E");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
